// File: rtl/alu_sweep_checker.sv
// alu_sweep_checker: exhaustive operand sweep of a 4-bit ALU for each selected
// opcode. Responses are compared against a built-in golden model; the checker
// keeps a saturating mismatch count and a snapshot of the first failing vector.
// Handshake: there is no backpressure. `start` is accepted only in IDLE, one
// vector is presented per ISSUE cycle, and the response to that vector is
// expected on alu_* inputs LAT cycles later. `done` pulses once per accepted start.
module alu_sweep_checker #(
    parameter int LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  op_mask,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [3:0]  alu_result,
    input  logic        alu_cout,
    input  logic        alu_overflow,
    input  logic        alu_zero,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_count,
    output logic        ff_valid,
    output logic [10:0] ff_vec,
    output logic [6:0]  ff_got,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam logic [2:0] DRAIN_LAST = 3'((LAT > 0) ? LAT - 1 : 0);

    state_t      state, state_nx;
    logic [7:0]  mask_q;
    logic [2:0]  op_q;
    logic [3:0]  a_q, b_q;
    logic [2:0]  drain_cnt;
    logic        issue_v;
    logic        accept;
    logic        end_vec;
    logic [7:0]  eff_mask;
    logic [3:0]  first_op, next_op;

    // Lowest set bit of mask at or above 'from'; MSB of the result flags "found".
    function automatic logic [3:0] find_op(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] res;
        res = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

    assign eff_mask = op_mask & 8'hF7;
    assign first_op = find_op(eff_mask, 4'd0);
    assign next_op  = find_op(mask_q, {1'b0, op_q} + 4'd1);
    assign end_vec  = (a_q == 4'hF) && (b_q == 4'hF) && !next_op[3];
    assign accept   = (state == S_IDLE) && start;

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = (eff_mask != 8'd0) ? S_ISSUE : S_DONE;
            S_ISSUE: if (end_vec) state_nx = (LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (drain_cnt == DRAIN_LAST) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy    = (state == S_ISSUE) || (state == S_DRAIN);
        done    = (state == S_DONE);
        issue_v = (state == S_ISSUE);
    end

    // Vector generator: b is the fastest digit, then a, then the opcode pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (accept) begin
            mask_q <= eff_mask;
            op_q   <= first_op[2:0];
            a_q    <= '0;
            b_q    <= '0;
        end else if (state == S_ISSUE) begin
            b_q <= b_q + 4'd1;
            if (b_q == 4'hF) begin
                a_q <= a_q + 4'd1;
                if (a_q == 4'hF && next_op[3]) op_q <= next_op[2:0];
            end
        end
    end

    // Drain counter: counts cycles spent waiting for in-flight responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 drain_cnt <= '0;
        else if (state == S_DRAIN)  drain_cnt <= drain_cnt + 3'd1;
        else                        drain_cnt <= '0;
    end

    // Golden model for the vector currently being driven
    logic [3:0] bb;
    logic [4:0] s;
    logic       g_ovf, g_lt;
    logic [3:0] g_res;
    always_comb begin
        bb    = op_q[2] ? ~b_q : b_q;
        s     = {1'b0, a_q} + {1'b0, bb} + {4'd0, op_q[2]};
        g_ovf = (a_q[3] == bb[3]) && (s[3] != a_q[3]);
        g_lt  = s[3] ^ g_ovf;
        case (op_q)
            3'b000:  g_res = a_q & b_q;
            3'b001:  g_res = a_q | b_q;
            3'b100:  g_res = a_q & ~b_q;
            3'b101:  g_res = a_q | ~b_q;
            3'b010:  g_res = s[3:0];
            3'b110:  g_res = s[3:0];
            3'b111:  g_res = {3'b000, g_lt};
            default: g_res = 4'd0;
        endcase
    end

    // Entry layout: {valid, op, a, b, exp_result, exp_cout, exp_ovf, exp_zero}
    logic [18:0] cur, chk;
    assign cur = {issue_v, op_q, a_q, b_q, g_res, s[4], g_ovf, (g_res == 4'd0)};

    generate
        if (LAT == 0) begin : g_comb
            assign chk = cur;
        end else begin : g_pipe
            logic [18:0] pipe [LAT];
            // Expected-value delay line, matched to the ALU response latency
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= cur;
                    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign chk = pipe[LAT-1];
        end
    endgenerate

    logic [6:0]  got;
    logic [10:0] chk_vec;
    logic [6:0]  chk_exp;
    logic        mism;
    assign got     = {alu_result, alu_cout, alu_overflow, alu_zero};
    assign chk_vec = chk[17:7];
    assign chk_exp = chk[6:0];
    // Flags cout/overflow only matter for arithmetic ops (op[1] set)
    assign mism = chk[18] && ((got[6:3] != chk_exp[6:3]) || (got[0] != chk_exp[0]) ||
                              (chk_vec[9] && (got[2:1] != chk_exp[2:1])));

    // Scoreboard: saturating mismatch count and first-failure snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            ff_valid  <= 1'b0;
            ff_vec    <= '0;
            ff_got    <= '0;
        end else if (accept) begin
            err_count <= '0;
            ff_valid  <= 1'b0;
            ff_vec    <= '0;
            ff_got    <= '0;
        end else if (mism) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            if (!ff_valid) begin
                ff_valid <= 1'b1;
                ff_vec   <= chk_vec;
                ff_got   <= got;
            end
        end
    end

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Bench for alu_sweep_checker: a combinational ALU (LAT=0) and a registered ALU
// (LAT=1), each with selectable faults, driving two checker instances.
module tb_alu_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, start1;
    logic [7:0]  mask0, mask1;
    logic [3:0]  a0, b0, a1, b1, r0, r1;
    logic [2:0]  op0, op1;
    logic        c0, v0, z0, c1, v1, z1;
    logic        busy0, done0, busy1, done1;
    logic [15:0] err0, err1;
    logic        ffv0, ffv1;
    logic [10:0] ffvec0, ffvec1;
    logic [6:0]  ffgot0, ffgot1;
    logic [1:0]  st0, st1;

    int          fault_mode;
    logic [10:0] glitch;
    int          cyc;
    int          errors;
    int          checks;

    // {cycle[66:35], err[34:19], ff_valid[18], ff_vec[17:7], ff_got[6:0]}
    logic [66:0] exp_q0[$];
    logic [66:0] exp_q1[$];
    logic [66:0] e0, e1;

    alu_sweep_checker #(.LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op_mask(mask0),
        .alu_a(a0), .alu_b(b0), .alu_op(op0),
        .alu_result(r0), .alu_cout(c0), .alu_overflow(v0), .alu_zero(z0),
        .busy(busy0), .done(done0), .err_count(err0), .ff_valid(ffv0),
        .ff_vec(ffvec0), .ff_got(ffgot0), .dbg_state(st0)
    );

    alu_sweep_checker #(.LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op_mask(mask1),
        .alu_a(a1), .alu_b(b1), .alu_op(op1),
        .alu_result(r1), .alu_cout(c1), .alu_overflow(v1), .alu_zero(z1),
        .busy(busy1), .done(done1), .err_count(err1), .ff_valid(ffv1),
        .ff_vec(ffvec1), .ff_got(ffgot1), .dbg_state(st1)
    );

    // ALU model with signed-integer arithmetic, plus optional faults:
    // 1 ADD result[0] stuck-at-0, 2 SLT uses raw sum MSB, 3 zero flipped on one
    // vector, 4 cout flipped on logic ops, 5 overflow flipped on SUB with a==b.
    function automatic logic [6:0] alu_f(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input int fm,
                                         input logic [10:0] gv);
        int ia, ib, sa, sb, r;
        logic [3:0] res;
        logic c, v, z;
        ia = int'(a); ib = int'(b);
        sa = a[3] ? ia - 16 : ia;
        sb = b[3] ? ib - 16 : ib;
        c = 1'b0; v = 1'b0; r = 0;
        case (op)
            3'd0: res = a & b;
            3'd1: res = a | b;
            3'd4: res = a & ~b;
            3'd5: res = a | ~b;
            3'd2: begin
                r = ia + ib; res = r[3:0]; c = (r > 15);
                v = (sa + sb > 7) || (sa + sb < -8);
            end
            3'd6, 3'd7: begin
                r = ia + (15 - ib) + 1; c = (r > 15);
                v = (sa - sb > 7) || (sa - sb < -8);
                res = (op == 3'd6) ? r[3:0] : {3'b000, (sa < sb)};
            end
            default: res = 4'd0;
        endcase
        if (fm == 1 && op == 3'd2) res[0] = 1'b0;
        if (fm == 2 && op == 3'd7) res = {3'b000, r[3]};
        z = (res == 4'd0);
        if (fm == 3 && {op, a, b} == gv) z = ~z;
        if (fm == 4 && !op[1]) c = ~c;
        if (fm == 5 && op == 3'd6 && a == b) v = ~v;
        return {res, c, v, z};
    endfunction

    always_comb {r0, c0, v0, z0} = alu_f(op0, a0, b0, fault_mode, glitch);
    always @(posedge clk) {r1, c1, v1, z1} <= alu_f(op1, a1, b1, fault_mode, glitch);

    always @(posedge clk) cyc <= cyc + 1;

    // Whole-sweep reference: walks every vector in order and tallies mismatches
    function automatic logic [66:0] ref_sweep(input logic [7:0] mask, input int lat,
                                              input int cyc_drive);
        int n, cnt;
        logic fv;
        logic [10:0] fvec;
        logic [6:0] fgot, got, gold;
        logic [2:0] op;
        logic [3:0] a, b;
        n = 0; cnt = 0; fv = 1'b0; fvec = '0; fgot = '0;
        for (int o = 0; o < 8; o++) begin
            if (mask[o] && o != 3) begin
                n++;
                op = 3'(o);
                for (int ia = 0; ia < 16; ia++) begin
                    for (int ib = 0; ib < 16; ib++) begin
                        a = 4'(ia); b = 4'(ib);
                        got  = alu_f(op, a, b, fault_mode, glitch);
                        gold = alu_f(op, a, b, 0, 11'd0);
                        if (got[6:3] != gold[6:3] || got[0] != gold[0] ||
                            (op[1] && got[2:1] != gold[2:1])) begin
                            cnt++;
                            if (!fv) begin fv = 1'b1; fvec = {op, a, b}; fgot = got; end
                        end
                    end
                end
            end
        end
        return {32'(cyc_drive + 1 + ((n == 0) ? 0 : 256 * n + lat)), 16'(cnt), fv, fvec, fgot};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor for the combinational-ALU checker
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done0 === 1'b1) begin
            if (exp_q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0_unexpected_done: got done=1 expected 0 at cyc %0d", cyc);
            end else begin
                e0 = exp_q0.pop_front();
                chk("dut0_done_cycle", 32'(cyc), e0[66:35]);
                chk("dut0_err_count", 32'(err0), 32'(e0[34:19]));
                chk("dut0_ff_valid", 32'(ffv0), 32'(e0[18]));
                chk("dut0_ff_vec", 32'(ffvec0), 32'(e0[17:7]));
                chk("dut0_ff_got", 32'(ffgot0), 32'(e0[6:0]));
                chk("dut0_busy_at_done", 32'(busy0), 32'd0);
            end
        end
    end

    // Monitor for the registered-ALU checker
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done1 === 1'b1) begin
            if (exp_q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1_unexpected_done: got done=1 expected 0 at cyc %0d", cyc);
            end else begin
                e1 = exp_q1.pop_front();
                chk("dut1_done_cycle", 32'(cyc), e1[66:35]);
                chk("dut1_err_count", 32'(err1), 32'(e1[34:19]));
                chk("dut1_ff_valid", 32'(ffv1), 32'(e1[18]));
                chk("dut1_ff_vec", 32'(ffvec1), 32'(e1[17:7]));
                chk("dut1_ff_got", 32'(ffgot1), 32'(e1[6:0]));
                chk("dut1_busy_at_done", 32'(busy1), 32'd0);
            end
        end
    end

    // Pulse start for one cycle; optionally record the expected sweep outcome
    task automatic sweep(input int which, input logic [7:0] mask, input bit push);
        @(negedge clk);
        if (which == 0) begin
            mask0 = mask; start0 = 1'b1;
            if (push) exp_q0.push_back(ref_sweep(mask, 0, cyc));
        end else begin
            mask1 = mask; start1 = 1'b1;
            if (push) exp_q1.push_back(ref_sweep(mask, 1, cyc));
        end
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic wait_done(input int which);
        int n;
        n = 0;
        while (((which == 0) ? exp_q0.size() : exp_q1.size()) != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        if (((which == 0) ? exp_q0.size() : exp_q1.size()) != 0) begin
            checks++; errors++;
            $display("FAIL dut%0d_done_timeout: got no done expected done within 4000 cycles", which);
            if (which == 0) exp_q0.delete(); else exp_q1.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero0(input string tag);
        chk({tag, "_alu_a"}, 32'(a0), 32'd0);
        chk({tag, "_alu_b"}, 32'(b0), 32'd0);
        chk({tag, "_alu_op"}, 32'(op0), 32'd0);
        chk({tag, "_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_done"}, 32'(done0), 32'd0);
        chk({tag, "_err_count"}, 32'(err0), 32'd0);
        chk({tag, "_ff_valid"}, 32'(ffv0), 32'd0);
        chk({tag, "_ff_vec"}, 32'(ffvec0), 32'd0);
        chk({tag, "_ff_got"}, 32'(ffgot0), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int which;
        errors = 0; checks = 0; cyc = 0;
        fault_mode = 0; glitch = '0;
        start0 = 1'b0; start1 = 1'b0; mask0 = '0; mask1 = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_zero0("reset");
        chk("reset_dut1_busy", 32'(busy1), 32'd0);
        chk("reset_dut1_err", 32'(err1), 32'd0);
        chk("reset_dut0_state", 32'(st0), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed sweeps on the combinational ALU
        fault_mode = 0; sweep(0, 8'h01, 1'b1); wait_done(0);
        fault_mode = 0; sweep(0, 8'hFF, 1'b1); wait_done(0);
        fault_mode = 1; sweep(0, 8'h04, 1'b1); wait_done(0);
        fault_mode = 2; sweep(0, 8'h80, 1'b1); wait_done(0);
        fault_mode = 0; sweep(0, 8'h08, 1'b1); wait_done(0);
        fault_mode = 4; sweep(0, 8'h33, 1'b1); wait_done(0);

        // Registered ALU, with a second start while busy that must be ignored
        fault_mode = 0;
        sweep(1, 8'h04, 1'b1);
        repeat (49) @(negedge clk);
        mask1 = 8'hFF; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1);
        fault_mode = 5; sweep(1, 8'hC4, 1'b1); wait_done(1);
        fault_mode = 0; sweep(1, 8'h00, 1'b1); wait_done(1);

        // Reset during vector 100 of a failing sweep: no done, everything cleared
        fault_mode = 1;
        sweep(0, 8'h04, 1'b0);
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero0("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        fault_mode = 0; sweep(0, 8'h04, 1'b1); wait_done(0);

        // Randomized sweeps
        for (int i = 0; i < 6; i++) begin
            which = int'($urandom_range(0, 1));
            fault_mode = int'($urandom_range(0, 5));
            glitch = {3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            sweep(which, 8'($urandom_range(0, 255)), 1'b1);
            wait_done(which);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
